// File: rtl/core_mem_responder_if.sv
// Request/response types and the core <-> memory responder bundle:
// two ports (fetch, data) plus status.
package core_mem_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } memreq;

  typedef struct packed {
    logic [31:0] data;
  } memresp;
endpackage

interface core_mem_responder_if;
  import core_mem_pkg::*;

  logic   fetch_request_enable;
  memreq  fetch_request;
  logic   fetch_response_enable;
  memresp fetch_response;
  logic   mem_request_enable;
  memreq  mem_request;
  logic   mem_response_enable;
  memresp mem_response;
  logic   busy;
  logic   protocol_error;

  modport master (
    output fetch_request_enable, fetch_request, mem_request_enable, mem_request,
    input  fetch_response_enable, fetch_response, mem_response_enable, mem_response,
    input  busy, protocol_error
  );

  modport slave (
    input  fetch_request_enable, fetch_request, mem_request_enable, mem_request,
    output fetch_response_enable, fetch_response, mem_response_enable, mem_response,
    output busy, protocol_error
  );
endinterface

// File: rtl/core_mem_responder.sv
// Two-port memory responder: one held request per port, mem-over-fetch priority,
// IDLE/ACCESS/RESPOND sequencing onto a single-port word RAM.
module core_mem_responder
  import core_mem_pkg::*;
#(
  parameter int    ADDR_WIDTH = 14,
  parameter string INIT_FILE  = ""
) (
  input  logic clk,
  input  logic rst,
  core_mem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  // Port index 0 is fetch, 1 is mem.
  state_t                  state_reg, state_next;
  logic [1:0]              req_en;
  memreq                   req [2];
  logic [1:0]              valid_reg;
  memreq                   hold_reg [2];
  logic [1:0]              grant;
  memreq                   access_reg;
  logic                    access_port_reg;
  logic                    protocol_error_reg;
  logic [1:0]              resp_en;
  logic [31:0]             resp_data_reg [2];
  logic [31:0]             resp_value;
  logic [31:0]             ram [0:(1<<ADDR_WIDTH)-1];
  logic [31:0]             ram_rdata_reg;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic                    unused_addr_bits;

  assign req_en = {bus.mem_request_enable, bus.fetch_request_enable};
  assign req[0] = bus.fetch_request;
  assign req[1] = bus.mem_request;

  always_comb begin
    state_next = state_reg;
    grant      = 2'b00;
    case (state_reg)
      IDLE, RESPOND: begin
        if (valid_reg[1])      grant = 2'b10;
        else if (valid_reg[0]) grant = 2'b01;
        state_next = (|valid_reg) ? ACCESS : IDLE;
      end
      ACCESS:  state_next = RESPOND;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg          <= IDLE;
      access_reg         <= '0;
      access_port_reg    <= 1'b0;
      protocol_error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (|grant) begin
        access_reg      <= grant[1] ? hold_reg[1] : hold_reg[0];
        access_port_reg <= grant[1];
      end
      // A pulse into an occupied register that is not being granted is lost.
      protocol_error_reg <= protocol_error_reg | (|(req_en & valid_reg & ~grant));
    end
  end

  assign resp_value = (access_reg.wstrb != 4'h0) ? 32'h0 : ram_rdata_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign resp_en[gi] = (state_reg == RESPOND) && (access_port_reg == (gi == 1));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg[gi]     <= 1'b0;
          hold_reg[gi]      <= '0;
          resp_data_reg[gi] <= 32'h0;
        end else begin
          // A new pulse landing on the grant edge refills the register.
          if (req_en[gi] && (!valid_reg[gi] || grant[gi])) begin
            valid_reg[gi] <= 1'b1;
            hold_reg[gi]  <= req[gi];
          end else if (grant[gi]) begin
            valid_reg[gi] <= 1'b0;
          end
          if (resp_en[gi]) resp_data_reg[gi] <= resp_value;
        end
      end
    end
  endgenerate

  // Only the word index is decoded; byte offset and high bits wrap.
  assign word_idx         = access_reg.addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{access_reg.addr[31:ADDR_WIDTH+2], access_reg.addr[1:0]};

  always_ff @(posedge clk) begin
    if (state_reg == ACCESS) begin
      for (int i = 0; i < 4; i++) begin
        if (access_reg.wstrb[i]) ram[word_idx][8*i +: 8] <= access_reg.wdata[8*i +: 8];
      end
      ram_rdata_reg <= ram[word_idx];
    end
  end

  assign bus.fetch_response_enable = resp_en[0];
  assign bus.fetch_response.data   = resp_en[0] ? resp_value : resp_data_reg[0];
  assign bus.mem_response_enable   = resp_en[1];
  assign bus.mem_response.data     = resp_en[1] ? resp_value : resp_data_reg[1];
  assign bus.busy                  = (state_reg != IDLE) || (|valid_reg);
  assign bus.protocol_error        = protocol_error_reg;

endmodule

// File: tb/tb_core_mem_responder.sv
// Directed + randomized bench for core_mem_responder against a word-array
// reference model; one line printed per transaction.
module tb_core_mem_responder;
  import core_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   monitor_on = 1'b0;
  logic [31:0] model_mem [int];

  always #5 clk = ~clk;

  core_mem_responder_if bus ();

  core_mem_responder #(.ADDR_WIDTH(14), .INIT_FILE("")) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic port_en(input bit p);
    return p ? bus.mem_response_enable : bus.fetch_response_enable;
  endfunction

  function automatic logic [31:0] port_data(input bit p);
    return p ? bus.mem_response.data : bus.fetch_response.data;
  endfunction

  function automatic int widx(input logic [31:0] addr);
    return int'(addr[15:2]);
  endfunction

  // Expected response for a request, updating the model for writes.
  function automatic logic [31:0] model_access(input logic [31:0] addr, input logic [31:0] wdata,
                                               input logic [3:0] wstrb);
    logic [31:0] old;
    old = model_mem.exists(widx(addr)) ? model_mem[widx(addr)] : 32'hx;
    if (wstrb == 4'h0) return old;
    for (int b = 0; b < 4; b++)
      if (wstrb[b]) old[8*b +: 8] = wdata[8*b +: 8];
    model_mem[widx(addr)] = old;
    return 32'h0;
  endfunction

  task automatic drive(input bit p, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb);
    if (p) begin
      bus.mem_request_enable = 1'b1;
      bus.mem_request        = '{addr: addr, wdata: wdata, wstrb: wstrb};
    end else begin
      bus.fetch_request_enable = 1'b1;
      bus.fetch_request        = '{addr: addr, wdata: wdata, wstrb: wstrb};
    end
  endtask

  task automatic clear_req();
    bus.fetch_request_enable = 1'b0;
    bus.mem_request_enable   = 1'b0;
  endtask

  // Single uncontended transaction: latency 3, correct data, data held afterwards.
  task automatic do_single(input string tag, input bit p, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
    logic [31:0] exp;
    int cyc;
    exp = model_access(addr, wdata, wstrb);
    drive(p, addr, wdata, wstrb);
    tick();
    clear_req();
    cyc = 1;
    while (!port_en(p) && cyc < 12) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, port_en(p) ? 32'(cyc) : 32'hFFFF_FFFF, 32'd3);
    check({tag, "_data"}, port_data(p), exp);
    check({tag, "_other_en"}, 32'(port_en(!p)), 32'd0);
    $display("txn %s port=%s addr=%h wstrb=%h wdata=%h resp=%h lat=%0d", tag,
             p ? "mem" : "fetch", addr, wstrb, wdata, port_data(p), cyc);
    tick();
    check({tag, "_pulse_end"}, 32'(port_en(p)), 32'd0);
    check({tag, "_held"}, port_data(p), exp);
  endtask

  always @(negedge clk) begin
    if (monitor_on && !rst) begin
      checks++;
      assert (!(bus.fetch_response_enable && bus.mem_response_enable)) else begin
        errors++;
        $error("FAIL overlap: observed=11 expected=not both");
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e_f, e_m, a, d;
    logic [3:0]  s;
    bit          p;
    int          k;

    clear_req();
    bus.fetch_request = '0;
    bus.mem_request   = '0;

    // Reset with clock running.
    repeat (3) tick();
    check("rst_fetch_en",   32'(bus.fetch_response_enable), 32'd0);
    check("rst_mem_en",     32'(bus.mem_response_enable),   32'd0);
    check("rst_fetch_data", bus.fetch_response.data, 32'h0);
    check("rst_mem_data",   bus.mem_response.data,   32'h0);
    check("rst_busy",       32'(bus.busy),           32'd0);
    check("rst_perr",       32'(bus.protocol_error), 32'd0);
    rst = 1'b0;
    monitor_on = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_ens",  32'({bus.fetch_response_enable, bus.mem_response_enable}), 32'd0);
    end

    // Write then read, byte strobes, wrap.
    do_single("wr_full",  1'b1, 32'h10,    32'hDEADBEEF, 4'hF);
    do_single("rd_full",  1'b1, 32'h10,    32'h0,        4'h0);
    do_single("wr_strb",  1'b1, 32'h10,    32'h11223344, 4'b0101);
    do_single("rd_strb",  1'b1, 32'h10,    32'h0,        4'h0);
    check("strb_value", model_mem[widx(32'h10)], 32'hDE22BE44);
    do_single("rd_wrap",  1'b1, 32'h10010, 32'h0,        4'h0);
    do_single("fwr_0",    1'b0, 32'h0,     32'hCAFEF00D, 4'hF);
    do_single("frd_0",    1'b0, 32'h0,     32'h0,        4'h0);

    // Contention: both ports pulsed in the same cycle.
    e_f = model_access(32'h0,  32'h0, 4'h0);
    e_m = model_access(32'h10, 32'h0, 4'h0);
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 32'h10, 32'h0, 4'h0);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) clear_req();
      check("cont_mem_en",   32'(bus.mem_response_enable),   32'(c == 3));
      check("cont_fetch_en", 32'(bus.fetch_response_enable), 32'(c == 5));
      if (c == 3) check("cont_mem_data",   bus.mem_response.data,   e_m);
      if (c == 5) check("cont_fetch_data", bus.fetch_response.data, e_f);
    end
    $display("txn contention fetch=%h mem=%h", bus.fetch_response.data, bus.mem_response.data);
    tick();

    // Protocol violation: second mem pulse while the first is still held.
    check("perr_before", 32'(bus.protocol_error), 32'd0);
    e_f = model_access(32'h0,  32'h0, 4'h0);
    e_m = model_access(32'h10, 32'h0, 4'h0);
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    clear_req();
    drive(1'b1, 32'h10, 32'h0, 4'h0);
    tick();
    check("perr_not_yet", 32'(bus.protocol_error), 32'd0);
    drive(1'b1, 32'h10, 32'h0, 4'hF);
    tick();
    clear_req();
    check("perr_set",        32'(bus.protocol_error), 32'd1);
    check("perr_fetch_en",   32'(bus.fetch_response_enable), 32'd1);
    check("perr_fetch_data", bus.fetch_response.data, e_f);
    tick();
    tick();
    check("perr_mem_en",   32'(bus.mem_response_enable), 32'd1);
    check("perr_mem_data", bus.mem_response.data, e_m);
    $display("txn protocol_error mem=%h perr=%0d", bus.mem_response.data, bus.protocol_error);
    tick();
    do_single("perr_reread", 1'b1, 32'h10, 32'h0, 4'h0);

    // Randomized traffic over a small set of words with random wrap/offset bits.
    for (int k2 = 0; k2 < 8; k2++) begin
      a = ($urandom & 32'hFFFF_0003) | ((32'h100 + 32'(k2)) << 2);
      do_single("rnd_init", 1'($urandom), a, $urandom, 4'hF);
    end
    for (int n = 0; n < 24; n++) begin
      k = int'($urandom_range(0, 7));
      p = 1'($urandom);
      a = ($urandom & 32'hFFFF_0003) | ((32'h100 + 32'(k)) << 2);
      d = $urandom;
      s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      do_single(s == 4'h0 ? "rnd_rd" : "rnd_wr", p, a, d, s);
    end
    check("perr_sticky", 32'(bus.protocol_error), 32'd1);

    // Reset during ACCESS of a read.
    drive(1'b1, 32'h10, 32'h0, 4'h0);
    tick();
    clear_req();
    tick();
    rst = 1'b1;
    #1;
    check("midrst_busy",  32'(bus.busy), 32'd0);
    check("midrst_ens",   32'({bus.fetch_response_enable, bus.mem_response_enable}), 32'd0);
    check("midrst_perr",  32'(bus.protocol_error), 32'd0);
    check("midrst_mdata", bus.mem_response.data, 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_ens",  32'({bus.fetch_response_enable, bus.mem_response_enable}), 32'd0);
      check("post_rst_busy", 32'(bus.busy), 32'd0);
    end
    $display("txn reset_mid_access busy=%0d", bus.busy);
    do_single("post_rst_rd", 1'b0, 32'h10, 32'h0, 4'h0);

    monitor_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
